// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction fields, opcodes,
// state encoding and opcode legality check.
package instruction_sequencer_pkg;

    localparam int unsigned IR_W   = 9;
    localparam int unsigned IMM_W  = 9;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned OP_W   = 3;

    // Instruction word field positions
    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RA_MSB = 5;
    localparam int unsigned RA_LSB = 3;
    localparam int unsigned RB_MSB = 2;
    localparam int unsigned RB_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_NAN = 3'b010;
    localparam logic [OP_W-1:0] OP_OUT = 3'b100;
    localparam logic [OP_W-1:0] OP_LDI = 3'b101;
    localparam logic [OP_W-1:0] OP_REP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_IMM  = 2'b01,
        S_EXEC = 2'b10
    } state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_NAN, OP_OUT, OP_LDI, OP_REP: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instruction_sequencer_step_counter.sv
// Two-bit step counter with enable, synchronous clear and a wrap flag raised
// while the counter is enabled at its terminal value.
module step_counter
    import instruction_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_wrap_c = i_en && (r_count == {CNT_W{1'b1}});

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/step stage: captures an instruction (and the LDI immediate), then walks
// the control unit through steps 00..11 and pulses done.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int unsigned IR_WIDTH  = IR_W,
    parameter int unsigned IMM_WIDTH = IMM_W
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [IR_WIDTH-1:0]  din,
    input  logic                 run,
    output logic [IR_WIDTH-1:0]  ir,
    output logic [IMM_WIDTH-1:0] imm,
    output logic [CNT_W-1:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   w_ir_nxt;
    logic [IMM_WIDTH-1:0]  r_imm;
    logic [IMM_WIDTH-1:0]  w_imm_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_illegal;
    logic                  w_illegal_nxt;
    logic                  w_cnt_en;
    logic                  w_cnt_clr;
    logic                  w_wrap;
    logic [OP_W-1:0]       w_op;
    logic [CNT_W-1:0]      w_count;

    assign w_op = din[OP_MSB:OP_LSB];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ir_nxt      = r_ir;
        w_imm_nxt     = r_imm;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_cnt_en      = 1'b0;
        w_cnt_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (run) begin
                    if (is_legal_op(w_op)) begin
                        w_ir_nxt    = din;
                        w_state_nxt = (w_op == OP_LDI) ? S_IMM : S_EXEC;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            S_IMM: begin
                w_cnt_clr = 1'b1;
                if (run) begin
                    w_imm_nxt   = IMM_WIDTH'(din);
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // Counter rolls 11->00 on the same edge that returns to idle
                w_cnt_en = 1'b1;
                if (w_wrap) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ir      <= '0;
            r_imm     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ir      <= w_ir_nxt;
            r_imm     <= w_imm_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    step_counter u_step_counter (
        .clock    (clock),
        .resetn   (resetn),
        .i_en     (w_cnt_en),
        .i_clr    (w_cnt_clr),
        .o_count  (w_count),
        .o_wrap_c (w_wrap)
    );

    assign ir      = r_ir;
    assign imm     = r_imm;
    assign count   = w_count;
    assign busy    = r_busy;
    assign done    = r_done;
    assign illegal = r_illegal;

endmodule
